// File: rtl/ahfp_pkg.sv
// Shared constants and types for the AHFP float-to-fixed datapath.
package ahfp_pkg;

    localparam int unsigned AHFP_W        = 32;
    localparam int unsigned AHFP_FIX_FRAC = 29;
    localparam int unsigned AHFP_MAX_REQ  = 8;

    typedef logic [AHFP_W-1:0] ahfp_word_t;

endpackage

// File: rtl/ahfp_float_2_fixed.sv
// Combinational IEEE-754 single to signed Q3.29 converter.
// Truncates toward zero, flushes denormals to zero, saturates |x| >= 4 (and Inf/NaN) by sign.
module ahfp_float_2_fixed
    import ahfp_pkg::*;
(
    input  ahfp_word_t operand,
    output ahfp_word_t result
);

    // Biased exponent at which the 24-bit significand needs no shift to land in Q3.29.
    localparam logic [7:0] ZERO_SHIFT_EXP = 8'(127 + 23 - AHFP_FIX_FRAC);

    logic        sign;
    logic [7:0]  expo;
    logic [23:0] mant;
    logic [7:0]  rsh;
    logic [30:0] mag;

    always_comb begin
        sign   = operand[31];
        expo   = operand[30:23];
        mant   = {1'b1, operand[22:0]};
        rsh    = '0;
        mag    = '0;
        result = '0;
        if (expo == 8'd0) begin
            result = '0;
        end else if (expo >= ZERO_SHIFT_EXP + 8'd8) begin
            result = sign ? 32'h8000_0000 : 32'h7fff_ffff;
        end else begin
            if (expo >= ZERO_SHIFT_EXP) begin
                mag = {7'd0, mant} << (expo - ZERO_SHIFT_EXP);
            end else begin
                rsh = ZERO_SHIFT_EXP - expo;
                mag = (rsh >= 8'd24) ? '0 : ({7'd0, mant} >> rsh);
            end
            result = sign ? -{1'b0, mag} : {1'b0, mag};
        end
    end

endmodule

// File: rtl/ahfp_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr, grant is gated by advance.
module ahfp_rr_arbiter #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[ID_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
        grant[grant_idx] = found & advance;
    end

endmodule

// File: rtl/ahfp_f2x_scheduler.sv
// Shares one float-to-fixed converter among NUM_REQ requesters through a
// round-robin arbiter and a two-stage valid/ready pipeline.
module ahfp_f2x_scheduler
    import ahfp_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [AHFP_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output ahfp_word_t                resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy
);

    logic            s1_valid, s2_valid;
    ahfp_word_t      s1_data, s2_data, conv_data;
    logic [ID_W-1:0] s1_id, s2_id, rr_ptr, grant_idx;
    logic            s1_en, s2_en, accept;

    assign s2_en = !s2_valid | resp_ready;
    assign s1_en = !s1_valid | s2_en;

    // Gating with reset_n keeps req_ready low for the whole reset cycle.
    ahfp_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .advance  (s1_en & reset_n),
        .grant    (req_ready),
        .grant_idx(grant_idx)
    );

    assign accept = |req_ready;

    ahfp_float_2_fixed u_conv (
        .operand(s1_data),
        .result (conv_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= req_data[{grant_idx, 5'd0} +: AHFP_W];
                    s1_id   <= grant_idx;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                s2_data  <= conv_data;
                s2_id    <= s1_id;
            end
            if (accept) begin
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign resp_valid = s2_valid;
    assign resp_data  = s2_data;
    assign resp_id    = s2_id;
    assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_ahfp_f2x_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_ahfp_f2x_scheduler;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [32*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [31:0]     resp_data;
    logic [1:0]      resp_id;
    logic            busy;

    always #5 clk = ~clk;

    ahfp_f2x_scheduler #(
        .NUM_REQ(NR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_id   (resp_id),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int obs_pops = 0;
    int obs_acc  = 0;

    // Reference model: in-flight operands in acceptance order with their age in edges.
    logic [31:0] q_data[$];
    int          q_id[$];
    int          q_age[$];
    int          m_ptr = 0;

    logic [NR-1:0] last_ready;
    logic          last_rv, last_busy;
    logic [31:0]   last_rdata;
    logic [1:0]    last_rid;

    logic [31:0] vals[8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000,
                             32'h3E800000, 32'h40600000, 32'hBE000000, 32'h00000000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Q3.29 value of an IEEE single: truncate toward zero, zero below normal range,
    // saturate magnitudes of 4 and above (including Inf/NaN).
    function automatic logic [31:0] f2x(input logic [31:0] f);
        int     e, sh;
        longint m, v;
        e = int'(f[30:23]);
        m = longint'({1'b1, f[22:0]});
        if (e == 0) return 32'h0;
        if (e - 127 >= 2) return f[31] ? 32'h8000_0000 : 32'h7fff_ffff;
        sh = e - 150 + 29;
        if (sh >= 0) v = m << sh;
        else if (sh <= -40) v = 0;
        else v = m >> (-sh);
        return f[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        case ($urandom_range(0, 15))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(129, 140));
            default: e = 8'($urandom_range(100, 128));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    function automatic logic [32*NR-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic cycle(input logic rst, input logic [NR-1:0] v, input logic [32*NR-1:0] d,
                         input logic rr);
        logic [NR-1:0] exp_ready;
        logic          exp_rv;
        int            win, idx;
        @(negedge clk);
        reset_n    = ~rst;
        req_valid  = v;
        req_data   = d;
        resp_ready = rr;
        #1;
        last_ready = req_ready;
        last_rv    = resp_valid;
        last_busy  = busy;
        last_rdata = resp_data;
        last_rid   = resp_id;
        exp_ready  = '0;
        win        = -1;
        exp_rv     = (q_data.size() > 0) && (q_age[0] >= 1);
        if (!rst && (q_data.size() < 2 || rr)) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        if (rst) begin
            check("ready_in_reset", 32'(req_ready), 32'h0);
        end else begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            check("busy", 32'(busy), 32'(q_data.size() > 0));
            if (exp_rv) begin
                check("resp_data", resp_data, q_data[0]);
                check("resp_id", 32'(resp_id), 32'(q_id[0]));
            end
        end
        @(posedge clk);
        if (rst) begin
            q_data.delete();
            q_id.delete();
            q_age.delete();
            m_ptr = 0;
        end else begin
            if (last_rv && rr) obs_pops++;
            if (|last_ready) obs_acc++;
            if (exp_rv && rr) begin
                void'(q_data.pop_front());
                void'(q_id.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i]++;
            if (win >= 0) begin
                q_data.push_back(f2x(d[32*win +: 32]));
                q_id.push_back(win);
                q_age.push_back(0);
                m_ptr = (win + 1) % NR;
            end
        end
    endtask

    initial begin
        logic [NR-1:0]    pend;
        logic [32*NR-1:0] rd;
        logic [31:0]      hold_data;
        logic [1:0]       hold_id;
        logic [31:0]      exp_tab[4];
        logic             rr, rst;
        int               accepts, vi;

        // Reset state
        cycle(1'b1, 4'b1111, pack4(vals[0], vals[1], vals[2], vals[3]), 1'b1);
        check("rst_ready", 32'(last_ready), 32'h0);
        cycle(1'b1, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        check("rst_resp_valid", 32'(last_rv), 32'h0);
        check("rst_busy", 32'(last_busy), 32'h0);
        check("rst_resp_data", last_rdata, 32'h0);
        check("rst_resp_id", 32'(last_rid), 32'h0);

        // Single request and latency
        cycle(1'b0, 4'b0001, pack4(32'h3F800000, 0, 0, 0), 1'b1);
        check("single_grant", 32'(last_ready), 32'h1);
        cycle(1'b0, '0, '0, 1'b1);
        check("single_not_yet", 32'(last_rv), 32'h0);
        cycle(1'b0, '0, '0, 1'b1);
        check("single_rv", 32'(last_rv), 32'h1);
        check("single_data", last_rdata, 32'h2000_0000);
        check("single_id", 32'(last_rid), 32'h0);
        cycle(1'b0, '0, '0, 1'b1);

        // Four simultaneous requests from reset
        cycle(1'b1, '0, '0, 1'b1);
        exp_tab = '{32'h2000_0000, 32'h0000_0000, 32'h0400_0000, 32'hE000_0000};
        pend = 4'b1111;
        rd = pack4(32'h3F800000, 32'h00000000, 32'h3E000000, 32'hBF800000);
        for (int t = 0; t < 6; t++) begin
            cycle(1'b0, pend, rd, 1'b1);
            if (t < 4) check("four_grant", 32'(last_ready), 32'(1 << t));
            if (t >= 2) begin
                check("four_rv", 32'(last_rv), 32'h1);
                check("four_data", last_rdata, exp_tab[t-2]);
                check("four_id", 32'(last_rid), 32'(t - 2));
            end
            pend &= ~last_ready;
        end

        // Alternation between 1 and 3, then wrap to 0
        cycle(1'b1, '0, '0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            cycle(1'b0, 4'b1010, pack4(0, vals[t], 0, vals[t+4]), 1'b1);
            check("alt_grant", 32'(last_ready), (t % 2 == 1) ? 32'h8 : 32'h2);
        end
        cycle(1'b0, 4'b1011, pack4(vals[7], vals[1], 0, vals[2]), 1'b1);
        check("wrap_grant", 32'(last_ready), 32'h1);
        for (int t = 0; t < 3; t++) cycle(1'b0, '0, '0, 1'b1);

        // Backpressure, then simultaneous pop and push
        cycle(1'b1, '0, '0, 1'b1);
        obs_pops = 0;
        obs_acc  = 0;
        accepts  = 0;
        vi       = 0;
        hold_data = '0;
        hold_id   = '0;
        for (int t = 0; t < 5; t++) begin
            cycle(1'b0, 4'b0001, pack4(vals[vi], 0, 0, 0), 1'b0);
            if (last_ready[0]) begin
                accepts++;
                vi++;
            end
            if (t == 2) begin
                hold_data = last_rdata;
                hold_id   = last_rid;
            end
        end
        check("bp_accepts", 32'(accepts), 32'h2);
        check("bp_ready_low", 32'(last_ready), 32'h0);
        check("bp_hold_data", last_rdata, hold_data);
        check("bp_hold_id", 32'(last_rid), 32'(hold_id));
        cycle(1'b0, 4'b0100, pack4(0, 0, 32'h3E000000, 0), 1'b1);
        check("pp_grant", 32'(last_ready), 32'h4);
        check("pp_pop", 32'(last_rv), 32'h1);
        cycle(1'b0, 4'b0001, pack4(vals[vi], 0, 0, 0), 1'b1);
        check("pp_no_bubble", 32'(last_rv), 32'h1);
        check("pp_next_grant", 32'(last_ready), 32'h1);
        for (int t = 0; t < 6; t++) cycle(1'b0, '0, '0, 1'b1);
        check("bp_all_out", 32'(obs_pops), 32'(obs_acc));

        // Reset mid-flight
        cycle(1'b0, 4'b0010, pack4(0, vals[3], 0, 0), 1'b0);
        cycle(1'b0, 4'b0010, pack4(0, vals[5], 0, 0), 1'b0);
        check("mf_fill", 32'(last_ready), 32'h2);
        cycle(1'b1, 4'b0010, pack4(0, vals[6], 0, 0), 1'b1);
        obs_pops = 0;
        cycle(1'b0, '0, '0, 1'b1);
        check("mf_rv", 32'(last_rv), 32'h0);
        check("mf_busy", 32'(last_busy), 32'h0);
        cycle(1'b0, 4'b1111, pack4(vals[0], vals[1], vals[2], vals[3]), 1'b1);
        check("mf_ptr_zero", 32'(last_ready), 32'h1);
        for (int t = 0; t < 5; t++) cycle(1'b0, '0, '0, 1'b1);
        check("mf_no_stale", 32'(obs_pops), 32'h1);

        // Randomized traffic
        pend = '0;
        rd   = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    rd[32*i +: 32] = rand_float();
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle(rst, pend, rd, rr);
            pend &= ~last_ready;
        end
        for (int t = 0; t < 4; t++) cycle(1'b0, '0, '0, 1'b1);
        check("final_idle", 32'(last_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
